// File: rtl/layer_seq_ctrl.sv
// Layer sequencer for the conv/pool datapath: one complete layer per start pulse.
// Optional compute-stall counter enabled by defining LAYER_SEQ_CTRL_PERF_CNT_EN.
module layer_seq_ctrl #(
    parameter int MAC_NUM = 256,
    parameter int PIX_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       operation,
    input  logic [4:0]       kernel_size,
    input  logic [11:0]      output_channel_size,
    input  logic [PIX_W-1:0] num_pixels,
    input  logic             ifmaps_fifo_empty,
    input  logic             weight_from_bram_valid,
    input  logic             write_weight_finish,
    input  logic             pooling_finish,
    output logic             axis_en,
    output logic             axis_clear,
    output logic             bram_write_en,
    output logic             bram_transfer_start,
    output logic             load_weight_preload,
    output logic             load_weight,
    output logic             load_ifmaps,
    output logic             pooling_compute,
    output logic             layer_finish,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [31:0]      stall_cycles
);

    localparam int MAC_SHIFT = $clog2(MAC_NUM);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_WR_W, S_XFER_W, S_PRE_W, S_LD_W,
        S_COMPUTE, S_FIN, S_WAIT_POOL, S_DONE, S_ABORT
    } state_e;

    state_e           state_q, state_d;
    logic             pool_q, pool_d;
    logic [9:0]       k2_m1_q, k2_m1_d;
    logic [PIX_W-1:0] pix_m1_q, pix_m1_d;
    logic [11:0]      grp_m1_q, grp_m1_d;
    logic [9:0]       beat_q, beat_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic [11:0]      grp_q, grp_d;
    logic             cfg_err_q, cfg_err_d;
    logic             axis_en_q, axis_en_d;
    logic             axis_clear_q, axis_clear_d;
    logic             bram_write_en_q, bram_write_en_d;
    logic             bram_xfer_q, bram_xfer_d;
    logic             preload_q, preload_d;
    logic             load_w_q, load_w_d;
    logic             layer_finish_q, layer_finish_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef LAYER_SEQ_CTRL_PERF_CNT_EN
    logic [31:0]      stall_q, stall_d;
`endif

    logic       cfg_illegal;
    logic       start_acc;
    logic       abort_hit;
    logic [9:0] k2;

    assign cfg_illegal = (operation > 2'd1) || (kernel_size == 5'd0) || (kernel_size > 5'd5) ||
                         (num_pixels == '0) || ((operation == 2'd0) && (output_channel_size == 12'd0));
    // busy stays high through the done cycle, so a start there is ignored too
    assign start_acc   = (state_q == S_IDLE) && start && !abort && !busy_q;
    assign abort_hit   = abort && (state_q != S_IDLE) && (state_q != S_ABORT);
    assign k2          = {5'd0, kernel_size} * {5'd0, kernel_size};

    assign load_ifmaps     = (state_q == S_COMPUTE) && !ifmaps_fifo_empty;
    assign pooling_compute = load_ifmaps && pool_q;

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
        state_d   = state_q;
        pool_d    = pool_q;
        k2_m1_d   = k2_m1_q;
        pix_m1_d  = pix_m1_q;
        grp_m1_d  = grp_m1_q;
        beat_d    = beat_q;
        pix_d     = pix_q;
        grp_d     = grp_q;
        cfg_err_d = cfg_err_q;

        case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    if (cfg_illegal) begin
                        cfg_err_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        cfg_err_d = 1'b0;
                        pool_d    = operation[0];
                        k2_m1_d   = k2 - 10'd1;
                        pix_m1_d  = num_pixels - 1'b1;
                        // ceil(ocs / MAC_NUM) - 1 without a wider intermediate
                        grp_m1_d  = (output_channel_size - 12'd1) >> MAC_SHIFT;
                        beat_d    = '0;
                        pix_d     = '0;
                        grp_d     = '0;
                        state_d   = S_CLEAR;
                    end
                end
            end
            S_CLEAR:     state_d = pool_q ? S_COMPUTE : S_WR_W;
            S_WR_W:      if (write_weight_finish) state_d = S_XFER_W;
            S_XFER_W:    if (weight_from_bram_valid) state_d = S_PRE_W;
            S_PRE_W:     state_d = S_LD_W;
            S_LD_W:      state_d = S_COMPUTE;
            S_COMPUTE: begin
                if (load_ifmaps) begin
                    if (beat_q == k2_m1_q) begin
                        beat_d = '0;
                        if (pix_q == pix_m1_q) state_d = S_FIN;
                        else                   pix_d   = pix_q + 1'b1;
                    end else begin
                        beat_d = beat_q + 10'd1;
                    end
                end
            end
            S_FIN: begin
                if (!pool_q && (grp_q < grp_m1_q)) begin
                    grp_d   = grp_q + 12'd1;
                    pix_d   = '0;
                    state_d = S_XFER_W;
                end else begin
                    state_d = pool_q ? S_WAIT_POOL : S_DONE;
                end
            end
            S_WAIT_POOL: if (pooling_finish) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            S_ABORT:     state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        if (abort_hit) begin
            state_d = S_ABORT;
            beat_d  = '0;
            pix_d   = '0;
            grp_d   = '0;
        end

        // Outputs are registered from the next state so each is valid in the cycle its state occupies
        axis_en_d       = (state_d == S_WR_W) || (state_d == S_COMPUTE);
        axis_clear_d    = (state_d == S_CLEAR) || (state_d == S_ABORT);
        bram_write_en_d = (state_d == S_WR_W);
        bram_xfer_d     = (state_d == S_XFER_W) && (state_q != S_XFER_W);
        preload_d       = (state_d == S_PRE_W);
        load_w_d        = (state_d == S_LD_W);
        layer_finish_d  = (state_d == S_FIN) && (pool_q || !(grp_q < grp_m1_q));
        done_d          = (state_q == S_DONE) && (state_d == S_IDLE);
        busy_d          = (state_d != S_IDLE) || done_d;

`ifdef LAYER_SEQ_CTRL_PERF_CNT_EN
        stall_d = stall_q;
        if ((state_q == S_COMPUTE) && ifmaps_fifo_empty && (stall_q != '1)) stall_d = stall_q + 32'd1;
        if (start_acc || abort_hit) stall_d = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            pool_q          <= 1'b0;
            k2_m1_q         <= '0;
            pix_m1_q        <= '0;
            grp_m1_q        <= '0;
            beat_q          <= '0;
            pix_q           <= '0;
            grp_q           <= '0;
            cfg_err_q       <= 1'b0;
            axis_en_q       <= 1'b0;
            axis_clear_q    <= 1'b0;
            bram_write_en_q <= 1'b0;
            bram_xfer_q     <= 1'b0;
            preload_q       <= 1'b0;
            load_w_q        <= 1'b0;
            layer_finish_q  <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
`ifdef LAYER_SEQ_CTRL_PERF_CNT_EN
            stall_q         <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q         <= state_d;
            pool_q          <= pool_d;
            k2_m1_q         <= k2_m1_d;
            pix_m1_q        <= pix_m1_d;
            grp_m1_q        <= grp_m1_d;
            beat_q          <= beat_d;
            pix_q           <= pix_d;
            grp_q           <= grp_d;
            cfg_err_q       <= cfg_err_d;
            axis_en_q       <= axis_en_d;
            axis_clear_q    <= axis_clear_d;
            bram_write_en_q <= bram_write_en_d;
            bram_xfer_q     <= bram_xfer_d;
            preload_q       <= preload_d;
            load_w_q        <= load_w_d;
            layer_finish_q  <= layer_finish_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
`ifdef LAYER_SEQ_CTRL_PERF_CNT_EN
            stall_q         <= stall_d;
`endif
        end
    end

    assign axis_en             = axis_en_q;
    assign axis_clear          = axis_clear_q;
    assign bram_write_en       = bram_write_en_q;
    assign bram_transfer_start = bram_xfer_q;
    assign load_weight_preload = preload_q;
    assign load_weight         = load_w_q;
    assign layer_finish        = layer_finish_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign cfg_err             = cfg_err_q;
`ifdef LAYER_SEQ_CTRL_PERF_CNT_EN
    assign stall_cycles        = stall_q;
`else
    assign stall_cycles        = '0;
`endif

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Scoreboard bench for layer_seq_ctrl: expected control pulses are queued at stimulus
// time and popped as the DUT produces them; a responder models the datapath status flags.
module tb_layer_seq_ctrl;

    localparam int EV_NONE  = 0;
    localparam int EV_CLEAR = 1;
    localparam int EV_XFER  = 2;
    localparam int EV_PRE   = 3;
    localparam int EV_LDW   = 4;
    localparam int EV_FIN   = 5;
    localparam int EV_DONE  = 6;

    logic        clk, rst, start, abort;
    logic [1:0]  operation;
    logic [4:0]  kernel_size;
    logic [11:0] output_channel_size;
    logic [15:0] num_pixels;
    logic        ifmaps_fifo_empty, weight_from_bram_valid, write_weight_finish, pooling_finish;
    logic        axis_en, axis_clear, bram_write_en, bram_transfer_start, load_weight_preload;
    logic        load_weight, load_ifmaps, pooling_compute, layer_finish, busy, done, cfg_err;
    logic [31:0] stall_cycles;
    logic [11:0] outs;

    int exp_q[$];
    int n_checks = 0, n_errors = 0;
    int cyc = 0, start_cyc = 0, clear_cyc = 0, done_cyc = 0, pf_cyc = 0, abort_cyc = 0, n_load = 0;
    int comp_start = 32'h7fff_ffff, model_beats = 0, beats_seen = 0, stall_model = 0;
    bit done_flag = 0, pool_mode = 0, fifo_toggle = 0;

    layer_seq_ctrl #(.MAC_NUM(256), .PIX_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .operation(operation),
        .kernel_size(kernel_size), .output_channel_size(output_channel_size), .num_pixels(num_pixels),
        .ifmaps_fifo_empty(ifmaps_fifo_empty), .weight_from_bram_valid(weight_from_bram_valid),
        .write_weight_finish(write_weight_finish), .pooling_finish(pooling_finish),
        .axis_en(axis_en), .axis_clear(axis_clear), .bram_write_en(bram_write_en),
        .bram_transfer_start(bram_transfer_start), .load_weight_preload(load_weight_preload),
        .load_weight(load_weight), .load_ifmaps(load_ifmaps), .pooling_compute(pooling_compute),
        .layer_finish(layer_finish), .busy(busy), .done(done), .cfg_err(cfg_err),
        .stall_cycles(stall_cycles)
    );

    assign outs = {axis_en, axis_clear, bram_write_en, bram_transfer_start, load_weight_preload,
                   load_weight, load_ifmaps, pooling_compute, layer_finish, busy, done, cfg_err};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic observe(input int ev);
        int e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", ev, EV_NONE);
        end else begin
            e = exp_q.pop_front();
            check("event_order", ev, e);
        end
    endtask

    task automatic push_conv_group();
        exp_q.push_back(EV_XFER);
        exp_q.push_back(EV_PRE);
        exp_q.push_back(EV_LDW);
    endtask

    // Monitor: samples away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (axis_clear) begin observe(EV_CLEAR); clear_cyc = cyc; end
            if (bram_transfer_start) observe(EV_XFER);
            if (load_weight_preload) observe(EV_PRE);
            if (load_weight)         observe(EV_LDW);
            if (layer_finish)        observe(EV_FIN);
            if (done) begin observe(EV_DONE); done_cyc = cyc; done_flag = 1'b1; end
            if (pooling_finish) pf_cyc = cyc;
            if (load_ifmaps) begin
                n_load++;
                check("load_while_empty", ifmaps_fifo_empty, 1'b0);
            end
            if (load_ifmaps || pooling_compute)
                check("pooling_compute", pooling_compute, load_ifmaps && pool_mode);
        end
    end

    // Datapath responder and stall model
    initial begin : responder
        int wr_cnt, xd, pd;
        wr_cnt = 0; xd = 0; pd = 0;
        ifmaps_fifo_empty = 1'b0; weight_from_bram_valid = 1'b0;
        write_weight_finish = 1'b0; pooling_finish = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bram_write_en && !rst) wr_cnt++; else wr_cnt = 0;
            write_weight_finish = bram_write_en && (wr_cnt == 5);
            if (bram_transfer_start) xd = 2; else if (xd != 0) xd--;
            weight_from_bram_valid = (xd == 1);
            if (layer_finish && pool_mode) pd = 3; else if (pd != 0) pd--;
            pooling_finish = (pd == 1);
            ifmaps_fifo_empty = fifo_toggle && (((cyc - start_cyc) % 2) == 1);
            if (model_beats != 0 && cyc >= comp_start && beats_seen < model_beats) begin
                if (ifmaps_fifo_empty) stall_model++;
                else                   beats_seen++;
            end
        end
    end

    task automatic start_layer(input logic [1:0] op, input logic [4:0] k,
                               input logic [11:0] ocs, input logic [15:0] np);
        @(posedge clk);
        #1;
        operation = op; kernel_size = k; output_channel_size = ocs; num_pixels = np;
        start = 1'b1;
        start_cyc = cyc;
        done_flag = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done_flag; i++) @(negedge clk);
        check("done_seen", done_flag, 1'b1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        operation = 2'd0; kernel_size = 5'd0; output_channel_size = 12'd0; num_pixels = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {20'd0, outs}, 32'd0);
        check("reset_stall", stall_cycles, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Conv, one group; a second start in WR_W must be ignored
        exp_q.push_back(EV_CLEAR); push_conv_group();
        exp_q.push_back(EV_FIN); exp_q.push_back(EV_DONE);
        n_load = 0;
        start_layer(2'd0, 5'd3, 12'd256, 16'd4);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(2000);
        check("t1_start_latency", clear_cyc - start_cyc, 1);
        check("t1_loads", n_load, 36);
        check("t1_events_left", exp_q.size(), 0);
        check("t1_cfg_err", cfg_err, 1'b0);
        repeat (2) @(negedge clk);
        check("t1_busy_after", busy, 1'b0);

        // Conv, three groups
        exp_q.push_back(EV_CLEAR);
        push_conv_group(); push_conv_group(); push_conv_group();
        exp_q.push_back(EV_FIN); exp_q.push_back(EV_DONE);
        n_load = 0;
        start_layer(2'd0, 5'd1, 12'd600, 16'd2);
        wait_done(2000);
        check("t2_loads", n_load, 6);
        check("t2_events_left", exp_q.size(), 0);

        // Pool with alternating FIFO empties
        pool_mode = 1'b1; fifo_toggle = 1'b1;
        stall_model = 0; beats_seen = 0; model_beats = 12; comp_start = 32'h7fff_ffff;
        pf_cyc = 0; n_load = 0;
        exp_q.push_back(EV_CLEAR); exp_q.push_back(EV_FIN); exp_q.push_back(EV_DONE);
        start_layer(2'd1, 5'd2, 12'd0, 16'd3);
        comp_start = start_cyc + 2;
        wait_done(2000);
        check("t3_loads", n_load, 12);
        check("t3_done_after_pool_finish", (pf_cyc > start_cyc) && (done_cyc > pf_cyc), 1'b1);
        check("t3_events_left", exp_q.size(), 0);
`ifdef LAYER_SEQ_CTRL_PERF_CNT_EN
        check("t3_stall_cycles", stall_cycles, stall_model);
`else
        check("t3_stall_cycles", stall_cycles, 32'd0);
`endif
        @(posedge clk); #1;
        pool_mode = 1'b0; fifo_toggle = 1'b0; model_beats = 0;

        // Illegal kernel size
        exp_q.push_back(EV_DONE);
        n_load = 0;
        start_layer(2'd0, 5'd6, 12'd256, 16'd4);
        wait_done(50);
        check("t4_done_latency", done_cyc - start_cyc, 2);
        check("t4_cfg_err", cfg_err, 1'b1);
        repeat (3) @(negedge clk);
        check("t4_cfg_err_held", cfg_err, 1'b1);
        check("t4_loads", n_load, 0);
        check("t4_events_left", exp_q.size(), 0);

        // Abort during COMPUTE at pixel 1, then a normal layer
        exp_q.push_back(EV_CLEAR); push_conv_group();
        n_load = 0;
        start_layer(2'd0, 5'd3, 12'd256, 16'd4);
        check("t5_cfg_err_cleared", cfg_err, 1'b0);
        for (int i = 0; i < 500 && n_load < 11; i++) @(negedge clk);
        check("t5_reach_pixel1", n_load >= 11, 1'b1);
        @(posedge clk); #1;
        abort = 1'b1;
        abort_cyc = cyc;
        exp_q.push_back(EV_CLEAR);
        @(posedge clk); #1 abort = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_abort_clear_latency", clear_cyc - abort_cyc, 1);
        check("t5_busy_after_abort", busy, 1'b0);
        check("t5_no_done", done_flag, 1'b0);
        check("t5_cfg_err_unchanged", cfg_err, 1'b0);
        check("t5_events_left", exp_q.size(), 0);
        exp_q.push_back(EV_CLEAR); push_conv_group();
        exp_q.push_back(EV_FIN); exp_q.push_back(EV_DONE);
        n_load = 0;
        start_layer(2'd0, 5'd3, 12'd256, 16'd4);
        wait_done(2000);
        check("t5_rerun_loads", n_load, 36);
        check("t5_rerun_events_left", exp_q.size(), 0);

        // Reset during WR_W, with an ignored start just before it
        exp_q.push_back(EV_CLEAR);
        start_layer(2'd0, 5'd3, 12'd256, 16'd4);
        for (int i = 0; i < 50 && !bram_write_en; i++) @(negedge clk);
        check("t6_reach_wr_w", bram_write_en, 1'b1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_reset_outputs", {20'd0, outs}, 32'd0);
        check("t6_reset_stall", stall_cycles, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_busy_after_reset", busy, 1'b0);
        check("t6_no_done", done_flag, 1'b0);
        check("t6_events_left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
